// File: rtl/layer7_weight_sched_if.sv
// Handshake and wrapper-control bundle between the weight sequencer, the
// weight-input path and the dual-read weight SRAM wrapper.
`timescale 1ns/1ps
interface layer7_weight_sched_if #(
    parameter int ADDR_W = 16
);
    logic              start_load;
    logic              w_in_valid;
    logic [15:0]       w_in_data;
    logic              w_in_ready;
    logic              compute_req;
    logic              compute_stall;
    logic              write_weight_signal;
    logic [15:0]       write_weight_data;
    logic [ADDR_W-1:0] write_weight_addr;
    logic              read_weight_signal;
    logic [ADDR_W-1:0] read_weight_addr1;
    logic [ADDR_W-1:0] read_weight_addr2;
    logic              rd_valid;
    logic              rd_last;
    logic              weights_loaded;
    logic              busy;

    modport master (
        output start_load, w_in_valid, w_in_data, compute_req, compute_stall,
        input  w_in_ready, write_weight_signal, write_weight_data, write_weight_addr,
               read_weight_signal, read_weight_addr1, read_weight_addr2,
               rd_valid, rd_last, weights_loaded, busy
    );

    modport slave (
        input  start_load, w_in_valid, w_in_data, compute_req, compute_stall,
        output w_in_ready, write_weight_signal, write_weight_data, write_weight_addr,
               read_weight_signal, read_weight_addr1, read_weight_addr2,
               rd_valid, rd_last, weights_loaded, busy
    );
endinterface

// File: rtl/layer7_weight_sched.sv
// Layer-7 weight sequencer: streams a weight set into the SRAM wrapper's serial
// write port, then walks its dual read port once per compute request.
`timescale 1ns/1ps
module layer7_weight_sched #(
    parameter int LOAD_WEIGHTS = 400,
    parameter int READ_WORDS   = 25,
    parameter int ADDR_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    layer7_weight_sched_if.slave bus
);
    localparam int LC_W   = $clog2(LOAD_WEIGHTS);
    localparam int RC_W   = $clog2(READ_WORDS);
    localparam int STAGES = 1;

    typedef enum logic [1:0] {IDLE, LOAD, LOADED, READ} state_t;

    state_t          state, state_nxt;
    logic [LC_W-1:0] load_cnt, load_cnt_nxt;
    logic [RC_W-1:0] rd_cnt, rd_cnt_nxt;
    logic            beat, load_last, issue, rd_end;
    logic [STAGES:1] vld_pipe, last_pipe;

    assign beat      = (state == LOAD) && bus.w_in_valid;
    assign load_last = beat && (load_cnt == LC_W'(LOAD_WEIGHTS - 1));
    assign issue     = (state == READ) && !bus.compute_stall;
    assign rd_end    = issue && (rd_cnt == RC_W'(READ_WORDS - 1));

    always_comb begin
        state_nxt    = state;
        load_cnt_nxt = load_cnt;
        rd_cnt_nxt   = rd_cnt;
        case (state)
            IDLE:   if (bus.start_load) state_nxt = LOAD;
            LOAD:   if (load_last) state_nxt = LOADED;
            LOADED: begin
                // a reload request takes priority over a compute request
                if (bus.start_load)       state_nxt = LOAD;
                else if (bus.compute_req) state_nxt = READ;
            end
            READ:   if (rd_end) state_nxt = LOADED;
            default: state_nxt = IDLE;
        endcase
        if (beat)  load_cnt_nxt = load_last ? '0 : load_cnt + 1'b1;
        if (issue) rd_cnt_nxt   = rd_end ? '0 : rd_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            load_cnt  <= '0;
            rd_cnt    <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            state        <= state_nxt;
            load_cnt     <= load_cnt_nxt;
            rd_cnt       <= rd_cnt_nxt;
            // wrapper samples read data on the falling edge; flag it a cycle later
            vld_pipe[1]  <= issue;
            last_pipe[1] <= rd_end;
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                last_pipe[s] <= last_pipe[s-1];
            end
        end
    end

    assign bus.w_in_ready          = (state == LOAD);
    assign bus.write_weight_signal = beat;
    assign bus.write_weight_data   = (state == LOAD) ? bus.w_in_data : '0;
    assign bus.write_weight_addr   = ADDR_W'(load_cnt);
    assign bus.read_weight_signal  = issue;
    assign bus.read_weight_addr1   = ADDR_W'(rd_cnt);
    assign bus.read_weight_addr2   = ADDR_W'(rd_cnt);
    assign bus.rd_valid            = vld_pipe[STAGES];
    assign bus.rd_last             = last_pipe[STAGES];
    assign bus.weights_loaded      = (state == LOADED) || (state == READ);
    assign bus.busy                = (state == LOAD) || (state == READ);
endmodule

// File: tb/tb_layer7_weight_sched.sv
// Scoreboard bench for layer7_weight_sched with a behavioural dual-bank wrapper
// that counts writes internally and serves 8-lane words on read.
`timescale 1ns/1ps
module tb_layer7_weight_sched;
    localparam int LW = 400;
    localparam int RW = 25;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    layer7_weight_sched_if #(.ADDR_W(AW)) bus ();

    layer7_weight_sched #(.LOAD_WEIGHTS(LW), .READ_WORDS(RW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int addr; int data; } wr_exp_t;
    typedef struct { int addr; bit last; int salt; } rd_exp_t;

    wr_exp_t     wq[$];
    rd_exp_t     rq[$];
    logic [15:0] mem [0:LW-1];
    int errs = 0, checks = 0;
    int wcnt = 0, wr_strobes = 0, rd_valids = 0, rd_lasts = 0;
    int pend_addr = 0, iss_exp = 0;
    bit in_read = 0;

    function automatic logic [15:0] wt(int salt, int i);
        return 16'((i * 3 + salt) & 16'hFFFF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // write side of the wrapper model plus write scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            wcnt = 0;
        end else if (bus.write_weight_signal) begin
            checks++;
            if (wq.size() == 0) begin
                errs++;
                $display("FAIL wr_unexpected addr=%0d data=%0d (no write expected)",
                         bus.write_weight_addr, bus.write_weight_data);
            end else begin
                wr_exp_t e;
                e = wq.pop_front();
                if (bus.write_weight_addr !== AW'(e.addr) || bus.write_weight_data !== 16'(e.data)) begin
                    errs++;
                    $display("FAIL wr_beat got addr=%0d data=%0d expected addr=%0d data=%0d",
                             bus.write_weight_addr, bus.write_weight_data, e.addr, e.data);
                end
            end
            mem[wcnt] = bus.write_weight_data;
            wcnt = (wcnt + 1) % LW;
            wr_strobes++;
        end
    end

    // read side: compare delivered words, then track the issue stream
    always @(negedge clk) begin
        if (rst) begin
            if (bus.rd_valid) begin
                checks++;
                rd_valids++;
                if (bus.rd_last) rd_lasts++;
                if (rq.size() == 0) begin
                    errs++;
                    $display("FAIL rd_unexpected word addr=%0d (no read expected)", pend_addr);
                end else begin
                    rd_exp_t e;
                    bit bad;
                    e = rq.pop_front();
                    bad = (pend_addr != e.addr) || (bus.rd_last !== e.last) || (pend_addr >= RW);
                    if (!bad)
                        for (int j = 0; j < 8; j++)
                            if (mem[pend_addr*8 + j] !== wt(e.salt, e.addr*8 + j) ||
                                mem[(pend_addr + RW)*8 + j] !== wt(e.salt, (e.addr + RW)*8 + j))
                                bad = 1;
                    if (bad) begin
                        errs++;
                        $display("FAIL rd_word got addr=%0d last=%0b expected addr=%0d last=%0b (or lane data differs)",
                                 pend_addr, bus.rd_last, e.addr, e.last);
                    end
                end
            end
            if (in_read) begin
                checks++;
                if (bus.read_weight_signal !== !bus.compute_stall ||
                    bus.read_weight_addr1 !== AW'(iss_exp) || bus.read_weight_addr2 !== AW'(iss_exp)) begin
                    errs++;
                    $display("FAIL rd_issue got sig=%0b a1=%0d a2=%0d expected sig=%0b addr=%0d",
                             bus.read_weight_signal, bus.read_weight_addr1, bus.read_weight_addr2,
                             !bus.compute_stall, iss_exp);
                end
                if (bus.read_weight_signal) begin
                    pend_addr = int'(bus.read_weight_addr1);
                    iss_exp++;
                    if (iss_exp == RW) begin
                        iss_exp = 0;
                        in_read = 0;
                    end
                end
            end else if (bus.read_weight_signal) begin
                checks++;
                errs++;
                $display("FAIL rd_spurious_issue addr=%0d (expected no issue)", bus.read_weight_addr1);
            end
        end
    end

    task automatic check_quiet(string name);
        checks++;
        if ({bus.w_in_ready, bus.write_weight_signal, bus.write_weight_data, bus.write_weight_addr,
             bus.read_weight_signal, bus.read_weight_addr1, bus.read_weight_addr2,
             bus.rd_valid, bus.rd_last, bus.weights_loaded, bus.busy} !== '0) begin
            errs++;
            $display("FAIL %s outputs: ready=%0b wsig=%0b wdata=%0d waddr=%0d rsig=%0b a1=%0d a2=%0d v=%0b l=%0b wl=%0b busy=%0b expected all 0",
                     name, bus.w_in_ready, bus.write_weight_signal, bus.write_weight_data,
                     bus.write_weight_addr, bus.read_weight_signal, bus.read_weight_addr1,
                     bus.read_weight_addr2, bus.rd_valid, bus.rd_last, bus.weights_loaded, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.start_load = 0; bus.w_in_valid = 0; bus.w_in_data = 16'h0;
        bus.compute_req = 0; bus.compute_stall = 0;
        rst = 0;
        #12;
        check_quiet("reset");
        tick();
        rst = 1;
        // compute_req and w_in_valid in IDLE must be ignored
        bus.compute_req = 1; bus.w_in_valid = 1; bus.w_in_data = 16'h1234;
        tick();
        bus.compute_req = 0; bus.w_in_valid = 0;
        tick();
        check_quiet("idle_ignore");
    endtask

    task automatic do_load(string name, int salt, bit gap, int misuse_at, int abort_at, bit both);
        int s0;
        s0 = wr_strobes;
        bus.start_load = 1;
        bus.compute_req = both;
        tick();
        bus.start_load = 0;
        bus.compute_req = 0;
        checks++;
        if (bus.w_in_ready !== 1'b1 || bus.weights_loaded !== 1'b0 || bus.busy !== 1'b1) begin
            errs++;
            $display("FAIL %s_enter ready=%0b wl=%0b busy=%0b expected 1 0 1",
                     name, bus.w_in_ready, bus.weights_loaded, bus.busy);
        end
        for (int i = 0; i < LW; i++) begin
            if (i == abort_at) begin
                bus.w_in_valid = 0;
                rst = 0;
                #2;
                check_quiet({name, "_abort"});
                wq.delete();
                tick();
                rst = 1;
                return;
            end
            if (gap) begin
                bus.w_in_valid = 0;
                bus.w_in_data = 16'hDEAD;
                tick();
            end
            bus.w_in_valid = 1;
            bus.w_in_data = wt(salt, i);
            bus.compute_req = (i == misuse_at);
            wq.push_back('{addr: i, data: int'(wt(salt, i))});
            if (i == LW - 1) begin
                checks++;
                if (bus.weights_loaded !== 1'b0) begin
                    errs++;
                    $display("FAIL %s_last_beat weights_loaded=%0b expected 0", name, bus.weights_loaded);
                end
            end
            tick();
        end
        bus.w_in_valid = 0;
        bus.compute_req = 0;
        checks++;
        if (bus.weights_loaded !== 1'b1 || bus.busy !== 1'b0 || bus.w_in_ready !== 1'b0) begin
            errs++;
            $display("FAIL %s_done wl=%0b busy=%0b ready=%0b expected 1 0 0",
                     name, bus.weights_loaded, bus.busy, bus.w_in_ready);
        end
        checks++;
        if (wr_strobes - s0 != LW || wq.size() != 0) begin
            errs++;
            $display("FAIL %s_count strobes=%0d pending=%0d expected %0d and 0",
                     name, wr_strobes - s0, wq.size(), LW);
        end
    endtask

    task automatic do_read(string name, int salt, int stall_at, int misuse_at);
        int v0, l0, cyc;
        v0 = rd_valids;
        l0 = rd_lasts;
        for (int k = 0; k < RW; k++) rq.push_back('{addr: k, last: (k == RW - 1), salt: salt});
        bus.compute_req = 1;
        tick();
        bus.compute_req = 0;
        in_read = 1;
        iss_exp = 0;
        cyc = 0;
        while (rd_lasts == l0 && cyc < 100) begin
            if (bus.rd_last === 1'b1) begin
                checks++;
                if (bus.busy !== 1'b0 || bus.weights_loaded !== 1'b1) begin
                    errs++;
                    $display("FAIL %s_last_state busy=%0b wl=%0b expected 0 1",
                             name, bus.busy, bus.weights_loaded);
                end
            end
            bus.compute_stall = (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
            bus.start_load = (cyc == misuse_at);
            tick();
            cyc++;
        end
        bus.compute_stall = 0;
        bus.start_load = 0;
        checks++;
        if (cyc >= 100) begin
            errs++;
            $display("FAIL %s_timeout rd_last not seen within 100 cycles", name);
        end
        checks++;
        if (rd_valids - v0 != RW || rq.size() != 0 || in_read) begin
            errs++;
            $display("FAIL %s_count valids=%0d pending=%0d in_read=%0b expected %0d 0 0",
                     name, rd_valids - v0, rq.size(), in_read, RW);
        end
        checks++;
        if (cyc != RW + 1 + ((stall_at >= 0) ? 3 : 0)) begin
            errs++;
            $display("FAIL %s_duration cycles=%0d expected %0d",
                     name, cyc, RW + 1 + ((stall_at >= 0) ? 3 : 0));
        end
        checks++;
        if (bus.weights_loaded !== 1'b1 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL %s_done wl=%0b busy=%0b expected 1 0", name, bus.weights_loaded, bus.busy);
        end
        in_read = 0;
    endtask

    task automatic test_load_b2b();   do_load("load_b2b", 0, 0, -1, -1, 0);     endtask
    task automatic test_read();       do_read("read", 0, -1, -1);               endtask
    task automatic test_load_gaps();  do_load("load_gaps", 1000, 1, -1, -1, 0); endtask
    task automatic test_back_to_back();
        do_read("read_gaps", 1000, -1, -1);
        do_read("read_again", 1000, -1, -1);
    endtask
    task automatic test_stall();      do_read("stall", 1000, 10, -1);           endtask
    task automatic test_misuse();
        do_load("reload_prio", 2000, 0, 50, -1, 1);
        do_read("read_misuse", 2000, -1, 5);
    endtask
    task automatic test_reset_mid_load();
        do_load("abort", 3000, 0, -1, 137, 0);
        checks++;
        if (bus.weights_loaded !== 1'b0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL abort_idle wl=%0b busy=%0b expected 0 0", bus.weights_loaded, bus.busy);
        end
        do_load("fresh", 4000, 0, -1, -1, 0);
        do_read("fresh_read", 4000, -1, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_b2b();
        test_read();
        test_load_gaps();
        test_back_to_back();
        test_stall();
        test_misuse();
        test_reset_mid_load();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
